// File: rtl/digit_product_accumulate.sv
// Digit-serial accumulator: resolves a redundant pair r0/r1 plus the shifted previous accumulator
// with a segmented carry-propagate add, one SEG-bit slice per cycle.
module digit_product_accumulate #(
    parameter int unsigned SIZE  = 3072,
    parameter int unsigned RADIX = 78,
    parameter int unsigned SEG   = 394,
    localparam int unsigned W    = SIZE + RADIX + 2,
    localparam int unsigned NSEG = (W + SEG - 1) / SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic             first,
    input  logic [W-1:0]     r0,
    input  logic [W-1:0]     r1,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     acc_out,
    output logic [RADIX-1:0] digit_out,
    output logic             carry_out,
    output logic             drop_err
);

    localparam int unsigned WP      = NSEG * SEG;
    localparam int unsigned LastW   = W - (NSEG - 1) * SEG;
    localparam int unsigned SumW    = SEG + 2;
    localparam int unsigned SegIdxW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e                       state_q, state_d;
    logic                         en_d_q, en_d_d;
    logic [SegIdxW-1:0]           seg_q, seg_d;
    logic [1:0]                   c_q, c_d;
    logic [NSEG-1:0][SEG-1:0]     op_a_q, op_a_d;
    logic [NSEG-1:0][SEG-1:0]     op_b_q, op_b_d;
    logic [NSEG-1:0][SEG-1:0]     op_c_q, op_c_d;
    logic [NSEG-1:0][SEG-1:0]     acc_nxt_q, acc_nxt_d;
    logic [W-1:0]                 acc_q, acc_d;
    logic                         carry_out_q, carry_out_d;
    logic                         done_q, done_d;
    logic                         busy_q, busy_d;
    logic                         drop_err_q, drop_err_d;

    logic                         start;
    logic [SumW-1:0]              sum_ext;
    logic [WP-1:0]                acc_flat;

    // Upstream holds en_in high after finishing, so only a rising edge starts an iteration.
    assign start = en_in & ~en_d_q;

    always_comb begin
        state_d     = state_q;
        en_d_d      = en_in;
        seg_d       = seg_q;
        c_d         = c_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        acc_nxt_d   = acc_nxt_q;
        acc_d       = acc_q;
        carry_out_d = carry_out_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        drop_err_d  = drop_err_q;
        sum_ext     = '0;
        acc_flat    = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_a_d  = WP'(r0);
                    op_b_d  = WP'(r1);
                    op_c_d  = first ? '0 : WP'(acc_q >> RADIX);
                    seg_d   = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                if (start) drop_err_d = 1'b1;
                sum_ext = SumW'(op_a_q[seg_q]) + SumW'(op_b_q[seg_q]) + SumW'(op_c_q[seg_q])
                        + SumW'(c_q);
                acc_nxt_d[seg_q] = sum_ext[SEG-1:0];
                c_d   = sum_ext[SEG+1:SEG];
                seg_d = seg_q + 1'b1;
                if (seg_q == SegIdxW'(NSEG - 1)) begin
                    acc_flat    = acc_nxt_d;
                    acc_d       = acc_flat[W-1:0];
                    // Anything above bit W of the top slice counts as overflow.
                    carry_out_d = |sum_ext[SEG+1:LastW];
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (start) drop_err_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            en_d_q      <= 1'b0;
            seg_q       <= '0;
            c_q         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            acc_nxt_q   <= '0;
            acc_q       <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_d_q      <= en_d_d;
            seg_q       <= seg_d;
            c_q         <= c_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            acc_nxt_q   <= acc_nxt_d;
            acc_q       <= acc_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign acc_out   = acc_q;
    assign digit_out = acc_q[RADIX-1:0];
    assign carry_out = carry_out_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_digit_product_accumulate.sv
// Scoreboard bench for digit_product_accumulate: stimulus pushes model results, a monitor pops
// and compares them on every done pulse.
module tb_digit_product_accumulate;

    localparam int unsigned SIZE  = 3072;
    localparam int unsigned RADIX = 78;
    localparam int unsigned SEG   = 394;
    localparam int unsigned W     = SIZE + RADIX + 2;
    localparam int unsigned NSEG  = (W + SEG - 1) / SEG;

    typedef struct {
        logic [W-1:0] acc;
        logic         carry;
        int unsigned  cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en_in = 1'b0;
    logic             first = 1'b0;
    logic [W-1:0]     r0 = '0;
    logic [W-1:0]     r1 = '0;
    logic             busy, done, carry_out, drop_err;
    logic [W-1:0]     acc_out;
    logic [RADIX-1:0] digit_out;

    exp_t         exp_q[$];
    logic [W-1:0] model_acc = '0;
    int unsigned  cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    digit_product_accumulate #(.SIZE(SIZE), .RADIX(RADIX), .SEG(SEG)) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .first(first), .r0(r0), .r1(r1),
        .busy(busy), .done(done), .acc_out(acc_out), .digit_out(digit_out),
        .carry_out(carry_out), .drop_err(drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got low64=%h required low64=%h (%0d bits differ)",
                     name, got[63:0], want[63:0], $countones(got ^ want));
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc_out", acc_out, e.acc);
                chk("digit_out", W'(digit_out), W'(e.acc[RADIX-1:0]));
                chk("carry_out", W'(carry_out), W'(e.carry));
                chk("latency", W'(cyc), W'(e.cyc));
                chk("busy_at_done", W'(busy), W'(0));
            end
        end
    end

    // Raise en_in with new operands; the model result is a plain wide add.
    task automatic issue(input bit f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] s;
        logic [W+1:0] prev;
        exp_t e;
        @(negedge clk);
        en_in = 1'b1;
        first = f;
        r0 = a;
        r1 = b;
        prev = f ? '0 : (W+2)'(model_acc >> RADIX);
        s = (W+2)'(a) + (W+2)'(b) + prev;
        e.acc = s[W-1:0];
        e.carry = |s[W+1:W];
        e.cyc = cyc + NSEG + 1;
        model_acc = e.acc;
        exp_q.push_back(e);
        @(negedge clk);
        r0 = rand_w();
        r1 = rand_w();
        first = $urandom_range(0, 1) != 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", W'(0), W'(1));
        @(negedge clk);
        en_in = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_acc", acc_out, W'(0));
        chk("rst_digit", W'(digit_out), W'(0));
        chk("rst_carry", W'(carry_out), W'(0));
        chk("rst_drop", W'(drop_err), W'(0));
        rst_n = 1'b1;

        // 1) small sum, checks latency via the monitor
        issue(1'b1, W'(5), W'(7));
        chk("t1_busy", W'(busy), W'(1));
        wait_done(NSEG + 5);
        chk("t1_acc", acc_out, W'(12));
        chk("t1_digit", W'(digit_out), W'(12));

        // 2) carry ripples through every slice
        issue(1'b1, ones, W'(1));
        wait_done(NSEG + 5);
        chk("t2_acc", acc_out, W'(0));
        chk("t2_carry", W'(carry_out), W'(1));

        // 3) shifted accumulator feeds the next digit
        issue(1'b1, W'(3) << RADIX, W'(5));
        wait_done(NSEG + 5);
        issue(1'b0, W'(1), W'(0));
        wait_done(NSEG + 5);
        chk("t3_acc", acc_out, W'(4));
        chk("t3_digit", W'(digit_out), W'(4));

        // 4) level held high: a single iteration only
        issue(1'b1, rand_w(), rand_w());
        repeat (40) @(negedge clk);
        en_in = 1'b0;
        chk("t4_drop", W'(drop_err), W'(0));
        chk("t4_idle", W'(busy), W'(0));

        // 5) second edge while busy is dropped
        issue(1'b1, rand_w(), rand_w());
        en_in = 1'b0;
        @(negedge clk);
        en_in = 1'b1;
        r0 = rand_w();
        wait_done(NSEG + 5);
        chk("t5_drop", W'(drop_err), W'(1));

        // 6) reset in the middle of an add
        issue(1'b1, rand_w(), rand_w());
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        en_in = 1'b0;
        exp_q.delete();
        model_acc = '0;
        @(negedge clk);
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_acc", acc_out, W'(0));
        chk("t6_drop", W'(drop_err), W'(0));
        chk("t6_done", W'(done), W'(0));
        rst_n = 1'b1;
        repeat (NSEG + 3) @(negedge clk);
        issue(1'b0, W'(9), W'(2));
        wait_done(NSEG + 5);
        chk("t6_after", acc_out, W'(11));

        // Random digit chains
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? ones : rand_w();
            issue((k == 0) ? 1'b1 : ($urandom_range(0, 1) != 0), a, rand_w());
            wait_done(NSEG + 5);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
